// File: rtl/traffic_interval_sequencer.sv
// Interval timer and car/pedestrian request front-end for the intersection light fsm.
// Produces level TS/TL timeouts and a debounced, latched car request C.
module traffic_interval_sequencer #(
    parameter int SHORT_CYCLES = 5,
    parameter int LONG_CYCLES  = 25,
    parameter int DEB_CYCLES   = 3,
    parameter int CNT_W        = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             ST,
    input  logic             CAR,
    input  logic             PB,
    input  logic             SG,
    output logic             TS,
    output logic             TL,
    output logic             C,
    output logic             PED_WAIT,
    output logic [CNT_W-1:0] CNT
);

    localparam logic [CNT_W-1:0] SHORT_C  = CNT_W'(SHORT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);
    localparam int               DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        T_RUN   = 2'd0,
        T_SHORT = 2'd1,
        T_LONG  = 2'd2
    } tstate_e;

    tstate_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             car_meta_q, car_s_q;
    logic             car_f_q, car_f_d;
    logic [DEB_W-1:0] deb_q, deb_d;

    logic             pb_meta_q, pb_s_q, pb_prev_q;
    logic             pb_rise_q, pb_rise_d;
    logic             ped_q, ped_d;
    logic             c_q, c_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ST) begin
            cnt_d   = '0;
            state_d = T_RUN;
        end else begin
            if (cnt_q != LONG_C) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Transitions key off the upcoming count so TS/TL rise on the same edge.
            case (state_q)
                T_RUN:   if (cnt_d == SHORT_C) state_d = T_SHORT;
                T_SHORT: if (cnt_d == LONG_C)  state_d = T_LONG;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        car_f_d = car_f_q;
        deb_d   = '0;
        if (car_s_q != car_f_q) begin
            if (deb_q == DEB_LAST) begin
                car_f_d = ~car_f_q;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end

        pb_rise_d = pb_s_q & ~pb_prev_q;

        // Side green serves the request, so it beats a simultaneous new press.
        ped_d = ped_q;
        if (SG) begin
            ped_d = 1'b0;
        end else if (pb_rise_q) begin
            ped_d = 1'b1;
        end

        c_d = car_f_d | ped_d;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= T_RUN;
            cnt_q      <= '0;
            car_meta_q <= 1'b0;
            car_s_q    <= 1'b0;
            car_f_q    <= 1'b0;
            deb_q      <= '0;
            pb_meta_q  <= 1'b0;
            pb_s_q     <= 1'b0;
            pb_prev_q  <= 1'b0;
            pb_rise_q  <= 1'b0;
            ped_q      <= 1'b0;
            c_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            car_meta_q <= CAR;
            car_s_q    <= car_meta_q;
            car_f_q    <= car_f_d;
            deb_q      <= deb_d;
            pb_meta_q  <= PB;
            pb_s_q     <= pb_meta_q;
            pb_prev_q  <= pb_s_q;
            pb_rise_q  <= pb_rise_d;
            ped_q      <= ped_d;
            c_q        <= c_d;
        end
    end

    assign TS       = (state_q != T_RUN);
    assign TL       = (state_q == T_LONG);
    assign C        = c_q;
    assign PED_WAIT = ped_q;
    assign CNT      = cnt_q;

endmodule

// File: doc/traffic_interval_sequencer.md
# traffic_interval_sequencer

Timing and request front-end for the intersection light controller `fsm`. It owns the phase interval counter: `fsm` restarts it with ST and receives level-type short/long timeouts back on TS/TL. It also turns the raw side-road car sensor and pedestrian push-button into the single clean car-request input `C` that `fsm` consumes. It sits between the board inputs and `fsm`, in the same Clk domain.

## Interface
- SHORT_CYCLES, default 5: cycles from timer start to TS assertion; legal range 1 to LONG_CYCLES-1.
- LONG_CYCLES, default 25: cycles from timer start to TL assertion; must be below 2^CNT_W.
- DEB_CYCLES, default 3: consecutive stable synchronized samples needed to change the filtered car level; must be at least 1.
- CNT_W, default 8: width of the interval counter.
- Clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ST  in  1  start-timer strobe from `fsm`; restarts the interval.
- CAR  in  1  raw asynchronous side-road vehicle sensor.
- PB  in  1  raw asynchronous pedestrian button.
- SG  in  1  side-road green from `fsm`; serves a pending pedestrian request.
- TS  out  1  short interval elapsed (level).
- TL  out  1  long interval elapsed (level).
- C  out  1  car/pedestrian request to `fsm`.
- PED_WAIT  out  1  pedestrian request pending (walk-wait lamp).
- CNT  out  CNT_W  current interval count, for debug.

## Operation
- Reset values: TS=0, TL=0, C=0, PED_WAIT=0, CNT=0. The timer state machine enters RUN. All synchronizer, debounce and edge-detect flops clear to 0. Reset overrides ST and every other input.
- Timer state machine:
  - RUN: counting, TS=0, TL=0.
  - SHORT: TS=1, TL=0.
  - LONG: TS=1, TL=1.
  - TS and TL are decoded from registered state, with no combinational path from any input.
  - ST=1 in any state: next edge gives CNT=0 and state RUN. ST has priority over the increment.
  - Otherwise CNT increments by 1 each edge, saturating at LONG_CYCLES.
  - RUN goes to SHORT on the edge where CNT becomes SHORT_CYCLES.
  - SHORT goes to LONG on the edge where CNT becomes LONG_CYCLES.
  - LONG holds with CNT frozen until ST or reset; there is no wrap-around.
  - ST held high continuously keeps CNT=0 and the state in RUN.
- Car filter:
  - CAR passes through a 2-flop synchronizer to produce car_s.
  - A debounce counter compares car_s against the filtered level car_f.
  - Each edge with car_s != car_f: if the counter equals DEB_CYCLES-1, car_f toggles and the counter clears; otherwise the counter increments.
  - Each edge with car_s == car_f: the counter clears.
  - The filter is symmetric: it applies to both rising and falling changes.
- Pedestrian latch:
  - PB passes through a 2-flop synchronizer plus one edge-detect flop.
  - A synchronized rising edge sets ped_pend.
  - SG=1 clears ped_pend and wins over a simultaneous set, so a press during side green is treated as already served.
  - A held button produces only one set.
- Outputs: C = car_f OR ped_pend, registered. PED_WAIT = ped_pend.

## Timing
- Edge k samples ST=1: after edge k, CNT=0. TS rises after edge k+SHORT_CYCLES, TL after edge k+LONG_CYCLES. Release of reset behaves exactly like ST.
- ST at edge k drops TS/TL after edge k with no bubble; there is no cycle where stale TS is seen.
- Car filter latency: a CAR change first sampled at edge e reaches C after edge e+DEB_CYCLES+1 (DEB_CYCLES=3 gives e+4).
  - A CAR pulse shorter than DEB_CYCLES cycles never reaches C.
  - A pulse of DEB_CYCLES or more cycles does reach C.
- Pedestrian latency: PB sampled high at edge e sets PED_WAIT and C after edge e+3. SG sampled high at edge s clears PED_WAIT after edge s.
- Reset mid-interval or mid-debounce aborts all progress; there is no partial carry-over.

## Test plan
- Reset release at edge r, ST=0 (defaults) -> TS=1 from edge r+5, TL=1 from edge r+25. CNT holds at 25 with TS=TL=1 for the next 50 cycles.
- ST one-cycle pulse when CNT=12 (state SHORT) -> after that edge CNT=0 and TS=0, then TS=1 again 5 edges later. ST held high for 40 cycles -> TS=TL=0 throughout.
- CAR glitches of 1 and 2 cycles -> C stays 0. CAR high for 3 cycles -> C=1, 4 edges after first sample. CAR then low for 10 cycles -> C=0, 4 edges after the fall.
- PB one-cycle pulse at edge e -> PED_WAIT=1 and C=1 after edge e+3. SG=1 at edge s -> both 0 after edge s. PB pressed while SG=1 -> PED_WAIT stays 0.
- PB rising edge coincident with SG=1 at the latch -> PED_WAIT stays 0. PB held high for 100 cycles -> exactly one set.
- Reset asserted mid-interval (CNT=17) and concurrently with ST=1 -> next edge all outputs 0, CNT=0. After release, TS returns 5 edges later.
